// File: rtl/spi_reg_responder_if.sv
// rtl/spi_reg_responder_if.sv - SPI pins and fabric register bus of spi_reg_responder
interface spi_reg_responder_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          spi_SCLK;
    logic          spi_SS_n;
    logic          spi_MOSI;
    logic          spi_MISO;
    logic          spi_MISO_oe;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_err;
    logic          addr_err;

    modport slave (
        input  spi_SCLK, spi_SS_n, spi_MOSI, rd_data,
        output spi_MISO, spi_MISO_oe, rd_addr, wr_valid, wr_addr, wr_data, frame_err, addr_err
    );

    modport master (
        output spi_SCLK, spi_SS_n, spi_MOSI, rd_data,
        input  spi_MISO, spi_MISO_oe, rd_addr, wr_valid, wr_addr, wr_data, frame_err, addr_err
    );
endinterface

// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 register responder; SPI_RESP_CRC_EN adds CRC-8 framing
module spi_reg_responder #(
    parameter int            NUM_REGS = 60,
    parameter int            DW       = 32,
    parameter int            AW       = 7,
    parameter logic [DW-1:0] BAD_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    spi_reg_responder_if.slave bus
);
`ifdef SPI_RESP_CRC_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif
    localparam int            FRAME_BITS = 8 + DW + CRC_BITS;
    localparam int            CW         = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_CMD   = CW'(7);
    localparam logic [CW-1:0] LAST_DATA  = CW'(8 + DW - 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(FRAME_BITS);

    typedef enum logic [2:0] {IDLE, CMD, DATA, CRC_RX, CRC_TX, DONE, WAIT_SS} state_t;

    state_t        state, state_n;
    logic [1:0]    sclk_sync, ss_sync, mosi_sync;
    logic          sclk_last;
    logic          rise, fall, ss_low, mosi, in_frame, abort, cmd_bad, crc_ok;
    logic          armed;
    logic [CW-1:0] bit_cnt;
    logic [7:0]    cmd_sr, cmd_full;
    logic [DW-1:0] rx_sr, tx_sr;
    logic          is_read, addr_bad;
    logic [1:0]    ld_pipe;

`ifdef SPI_RESP_CRC_EN
    logic [7:0] crc, crc_rx;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    assign crc_ok = (crc == crc_rx);
`else
    assign crc_ok = 1'b1;
`endif

    assign rise     = sclk_sync[1] & ~sclk_last;
    assign fall     = ~sclk_sync[1] & sclk_last;
    assign ss_low   = ~ss_sync[1];
    assign mosi     = mosi_sync[1];
    assign cmd_full = {cmd_sr[6:0], mosi};
    assign cmd_bad  = cmd_full[AW-1:0] >= AW'(NUM_REGS);
    assign in_frame = (state == CMD) || (state == DATA) || (state == CRC_RX) || (state == CRC_TX);

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        case (state)
            IDLE: if (ss_low && armed) state_n = CMD;
            CMD: begin
                if (!ss_low) begin
                    state_n = IDLE;
                    abort   = (bit_cnt != '0);
                end else if (rise && bit_cnt == LAST_CMD) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (!ss_low) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end else if (rise && bit_cnt == LAST_DATA) begin
`ifdef SPI_RESP_CRC_EN
                    state_n = is_read ? CRC_TX : CRC_RX;
`else
                    state_n = DONE;
`endif
                end
            end
            CRC_RX, CRC_TX: begin
                if (!ss_low) begin
                    state_n = IDLE;
                    abort   = 1'b1;
                end else if (rise && bit_cnt == LAST_BIT) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = WAIT_SS;
            WAIT_SS: if (!ss_low) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_n;
    end

    // Synchronisers stay unreset so a reset inside a frame still sees SS_n low and waits it out.
    always_ff @(posedge clk_clk) begin
        sclk_sync <= {sclk_sync[0], bus.spi_SCLK};
        ss_sync   <= {ss_sync[0], bus.spi_SS_n};
        mosi_sync <= {mosi_sync[0], bus.spi_MOSI};
        sclk_last <= sclk_sync[1];
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            armed           <= 1'b0;
            bit_cnt         <= '0;
            cmd_sr          <= '0;
            rx_sr           <= '0;
            tx_sr           <= '0;
            is_read         <= 1'b0;
            addr_bad        <= 1'b0;
            ld_pipe         <= '0;
            bus.spi_MISO    <= 1'b0;
            bus.spi_MISO_oe <= 1'b0;
            bus.rd_addr     <= '0;
            bus.wr_valid    <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.frame_err   <= 1'b0;
            bus.addr_err    <= 1'b0;
`ifdef SPI_RESP_CRC_EN
            crc             <= '0;
            crc_rx          <= '0;
`endif
        end else begin
            armed           <= armed | ~ss_low;
            bus.spi_MISO_oe <= ss_low;
            bus.wr_valid    <= 1'b0;
            bus.frame_err   <= abort;
            bus.addr_err    <= 1'b0;
            ld_pipe         <= {ld_pipe[0], 1'b0};

            // rd_data answers one clk after rd_addr, so the word is captured two clks after the cmd.
            if (ld_pipe[1]) tx_sr <= addr_bad ? BAD_DATA : bus.rd_data;

            if (state == IDLE) begin
                bit_cnt      <= '0;
                bus.spi_MISO <= 1'b0;
`ifdef SPI_RESP_CRC_EN
                crc          <= '0;
`endif
            end

            if (in_frame && ss_low && rise) begin
                if (bit_cnt != MAX_CNT) bit_cnt <= bit_cnt + 1'b1;
                case (state)
                    CMD: begin
                        cmd_sr <= cmd_full;
`ifdef SPI_RESP_CRC_EN
                        crc    <= crc8_step(crc, mosi);
`endif
                        if (bit_cnt == LAST_CMD) begin
                            bus.rd_addr <= cmd_full[AW-1:0];
                            is_read     <= cmd_full[7];
                            addr_bad    <= cmd_bad;
                            if (cmd_full[7]) begin
                                ld_pipe[0]   <= 1'b1;
                                bus.addr_err <= cmd_bad;
                            end
                        end
                    end
                    DATA: begin
                        if (!is_read) begin
                            rx_sr <= {rx_sr[DW-2:0], mosi};
`ifdef SPI_RESP_CRC_EN
                            crc   <= crc8_step(crc, mosi);
                        end else if (bit_cnt == LAST_DATA) begin
                            tx_sr <= {crc, {(DW-8){1'b0}}};
`endif
                        end
                    end
`ifdef SPI_RESP_CRC_EN
                    CRC_RX: crc_rx <= {crc_rx[6:0], mosi};
`endif
                    default: ;
                endcase
            end

            if (ss_low && fall && ((state == DATA && is_read) || state == CRC_TX)) begin
                bus.spi_MISO <= tx_sr[DW-1];
                tx_sr        <= {tx_sr[DW-2:0], 1'b0};
`ifdef SPI_RESP_CRC_EN
                if (state == DATA) crc <= crc8_step(crc, tx_sr[DW-1]);
`endif
            end

            if (state == DONE && !is_read) begin
                if (!crc_ok) begin
                    bus.frame_err <= 1'b1;
                end else if (addr_bad) begin
                    bus.addr_err <= 1'b1;
                end else begin
                    bus.wr_valid <= 1'b1;
                    bus.wr_addr  <= cmd_sr[AW-1:0];
                    bus.wr_data  <= rx_sr;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - directed self-checking bench for spi_reg_responder
module tb_spi_reg_responder;
`ifdef SPI_RESP_CRC_EN
    localparam int FL = 48;
`else
    localparam int FL = 40;
`endif
    localparam int CB = FL - 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt = 0, ferr_cnt = 0, aerr_cnt = 0, oe_bad = 0, oe_hi = 0;
    logic [6:0]  last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [4:0]  ss_hist = '1;
    logic [2:0]  rst_hist = '1;
    logic [63:0] rx, v;
    logic        m;

    spi_reg_responder_if bus ();

    spi_reg_responder dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rd_data <= (bus.rd_addr == 7'd10) ? 32'hCAFE_F00D : (32'h1111_0000 | 32'(bus.rd_addr));

    always @(negedge clk) begin
        if (bus.wr_valid) begin
            wr_cnt++;
            last_wa = bus.wr_addr;
            last_wd = bus.wr_data;
        end
        if (bus.frame_err) ferr_cnt++;
        if (bus.addr_err) aerr_cnt++;
        ss_hist  = {ss_hist[3:0], bus.spi_SS_n};
        rst_hist = {rst_hist[1:0], rst};
        if (rst_hist == 3'b000 && (ss_hist == 5'h1f || ss_hist == 5'h00)) begin
            if (bus.spi_MISO_oe !== ~ss_hist[0]) oe_bad++;
            if (bus.spi_MISO_oe) oe_hi++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic mi);
        bus.spi_MOSI = b;
        tick(4);
        bus.spi_SCLK = 1'b1;
        mi = bus.spi_MISO;
        tick(4);
        bus.spi_SCLK = 1'b0;
    endtask

    task automatic frame(input logic [63:0] bits, input int n, input int nsend, output logic [63:0] r);
        logic mi;
        r = '0;
        bus.spi_SS_n = 1'b0;
        tick(4);
        for (int i = 0; i < nsend; i++) begin
            spi_bit(bits[n-1-i], mi);
            r = {r[62:0], mi};
        end
        tick(4);
        bus.spi_SS_n = 1'b1;
        tick(8);
    endtask

`ifdef SPI_RESP_CRC_EN
    function automatic logic [7:0] crc8(input logic [39:0] msg);
        logic [7:0] c = '0;
        for (int i = 39; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ msg[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    function automatic logic [63:0] mk(input logic [7:0] c, input logic [31:0] d);
`ifdef SPI_RESP_CRC_EN
        return {16'h0, c, d, crc8({c, d})};
`else
        return {24'h0, c, d};
`endif
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.spi_SS_n = 1'b1;
        bus.spi_SCLK = 1'b0;
        bus.spi_MOSI = 1'b0;
        tick(6);
        rst = 1'b0;
        tick(2);
        chk("rst_miso", bus.spi_MISO, 0);
        chk("rst_oe", bus.spi_MISO_oe, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_addr_err", bus.addr_err, 0);

        frame(mk(8'h05, 32'h1234_5678), FL, FL, rx);
        chk("wr1_count", wr_cnt, 1);
        chk("wr1_addr", last_wa, 7'h05);
        chk("wr1_data", last_wd, 32'h1234_5678);
        chk("wr1_frame_err", ferr_cnt, 0);
        chk("wr1_addr_err", aerr_cnt, 0);

        frame(mk(8'h8A, 32'h0), FL, FL, rx);
        chk("rd10_data", 32'(rx >> CB), 32'hCAFE_F00D);
        chk("rd10_cmd_phase_miso", 8'(rx >> (CB + 32)), 8'h00);
        chk("rd10_no_write", wr_cnt, 1);
        chk("rd10_oe_track", oe_bad, 0);
        chk("rd10_oe_seen", oe_hi > 0, 1);

        frame(mk(8'hFF, 32'h0), FL, FL, rx);
        chk("rd7f_bad_data", 32'(rx >> CB), 32'hDEAD_BEEF);
        chk("rd7f_addr_err", aerr_cnt, 1);
        frame(mk(8'h40, 32'h0BAD_0BAD), FL, FL, rx);
        chk("wr40_addr_err", aerr_cnt, 2);
        chk("wr40_no_write", wr_cnt, 1);

        bus.spi_SS_n = 1'b0;
        tick(6);
        bus.spi_SS_n = 1'b1;
        tick(8);
        chk("zero_bits_no_err", ferr_cnt, 0);

        frame(mk(8'h03, 32'hA5A5_0F0F), FL, 20, rx);
        chk("abort_frame_err", ferr_cnt, 1);
        chk("abort_no_write", wr_cnt, 1);
        frame(mk(8'h03, 32'hA5A5_0F0F), FL, FL, rx);
        chk("after_abort_count", wr_cnt, 2);
        chk("after_abort_data", last_wd, 32'hA5A5_0F0F);

        v = mk(8'h07, 32'h5555_AAAA);
        bus.spi_SS_n = 1'b0;
        tick(4);
        for (int i = 0; i < 15; i++) spi_bit(v[FL-1-i], m);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("midrst_wr_addr", bus.wr_addr, 0);
        for (int i = 15; i < FL; i++) spi_bit(v[FL-1-i], m);
        tick(4);
        bus.spi_SS_n = 1'b1;
        tick(8);
        chk("midrst_no_write", wr_cnt, 2);
        chk("midrst_no_frame_err", ferr_cnt, 1);
        frame(mk(8'h3B, 32'h0BAD_F00D), FL, FL, rx);
        chk("wr59_count", wr_cnt, 3);
        chk("wr59_addr", last_wa, 7'h3B);
        chk("wr59_data", last_wd, 32'h0BAD_F00D);
        frame(mk(8'h3C, 32'h1), FL, FL, rx);
        chk("wr60_addr_err", aerr_cnt, 3);
        chk("wr60_no_write", wr_cnt, 3);

        frame((mk(8'h11, 32'h8765_4321) << 2) | 64'h3, FL + 2, FL + 2, rx);
        chk("extra_bits_count", wr_cnt, 4);
        chk("extra_bits_data", last_wd, 32'h8765_4321);
        chk("extra_bits_no_err", ferr_cnt, 1);

`ifdef SPI_RESP_CRC_EN
        frame({16'h0, 8'h01, 32'h0000_00FF, 8'h91}, FL, FL, rx);
        chk("crc_ok_count", wr_cnt, 5);
        chk("crc_ok_data", last_wd, 32'h0000_00FF);
        frame({16'h0, 8'h01, 32'h0000_00FF, 8'h90}, FL, FL, rx);
        chk("crc_bad_frame_err", ferr_cnt, 2);
        chk("crc_bad_no_write", wr_cnt, 5);
`endif

        chk("final_oe_track", oe_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
